// File: rtl/parse_pkg.sv
// Shared defaults, state encoding and derived widths for the rejection-sampling parser.
package parse_pkg;

  localparam int unsigned DEF_IN_W   = 64;
  localparam int unsigned DEF_COEF_W = 12;
  localparam int unsigned DEF_Q      = 3329;
  localparam int unsigned DEF_LANES  = 5;
  localparam int unsigned DEF_N_COEF = 256;

  localparam int unsigned DEF_BUF_W  = 2 * DEF_IN_W;
  localparam int unsigned DEF_CNT_W  = $clog2(DEF_BUF_W + 1);
  localparam int unsigned DEF_ACC_W  = $clog2(DEF_N_COEF + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/parse_lane_check.sv
// Single-lane acceptance test: a candidate survives rejection iff it is below the modulus.
module parse_lane_check
  import parse_pkg::*;
#(
  parameter int unsigned COEF_W = DEF_COEF_W,
  parameter int unsigned Q      = DEF_Q
) (
  input  logic [COEF_W-1:0] cand,
  output logic              accept
);

  assign accept = (32'(cand) < 32'(Q));

endmodule

// File: rtl/parse_sampler_stream.sv
// Rejection-sampling parser: bit gearbox, per-lane < Q check, masked beats until N_COEF accepted.
// Build option PARSE_STATS_EN adds a saturating rejected-candidate counter on rej_cnt.
module parse_sampler_stream
  import parse_pkg::*;
#(
  parameter int unsigned IN_W   = DEF_IN_W,
  parameter int unsigned COEF_W = DEF_COEF_W,
  parameter int unsigned Q      = DEF_Q,
  parameter int unsigned LANES  = DEF_LANES,
  parameter int unsigned N_COEF = DEF_N_COEF
) (
  input  logic                      clk,
  input  logic                      resetb,
  input  logic                      start,
  input  logic [IN_W-1:0]           in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [LANES*COEF_W-1:0]   out_coef,
  output logic [LANES-1:0]          out_mask,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      done,
  output logic [15:0]               rej_cnt
);

  localparam int unsigned BUF_W = 2 * IN_W;
  localparam int unsigned EXT_W = LANES * COEF_W;
  localparam int unsigned CNT_W = $clog2(BUF_W + 1);
  localparam int unsigned ACC_W = $clog2(N_COEF + 1);

  state_e             state_r;
  logic [BUF_W-1:0]   buf_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [ACC_W-1:0]   acc_cnt_r;
  logic [EXT_W-1:0]   out_coef_r;
  logic [LANES-1:0]   out_mask_r;
  logic               out_valid_r;

  logic               run_s;
  logic               in_ready_s;
  logic               ld_s;
  logic               ext_s;
  logic [BUF_W-1:0]   shifted_s;
  logic [CNT_W-1:0]   pos_s;
  logic [BUF_W-1:0]   buf_next_s;
  logic [CNT_W-1:0]   cnt_next_s;
  logic [COEF_W-1:0]  cand_s [LANES];
  logic [LANES-1:0]   lane_ok_s;
  logic [LANES-1:0]   mask_s;
  logic [ACC_W-1:0]   remain_s;
  logic [ACC_W-1:0]   take_cnt_s;
  logic [ACC_W-1:0]   acc_next_s;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign cand_s[g] = buf_r[g*COEF_W +: COEF_W];
    parse_lane_check #(.COEF_W(COEF_W), .Q(Q)) u_check (
      .cand   (cand_s[g]),
      .accept (lane_ok_s[g])
    );
  end

  // Handshake decisions and gearbox next-state; the load lands just above the surviving bits.
  always_comb begin
    run_s      = (state_r == ST_RUN);
    in_ready_s = run_s && (cnt_r <= CNT_W'(BUF_W - IN_W));
    ld_s       = in_valid && in_ready_s;
    ext_s      = run_s && (cnt_r >= CNT_W'(EXT_W)) && (!out_valid_r || out_ready);
    shifted_s  = ext_s ? (buf_r >> EXT_W) : buf_r;
    pos_s      = ext_s ? (cnt_r - CNT_W'(EXT_W)) : cnt_r;
    if (ld_s) begin
      buf_next_s = shifted_s | ({{(BUF_W-IN_W){1'b0}}, in_data} << pos_s);
      cnt_next_s = pos_s + CNT_W'(IN_W);
    end else begin
      buf_next_s = shifted_s;
      cnt_next_s = pos_s;
    end
  end

  // Priority truncation: keep only the lowest-index accepted lanes that still fit under N_COEF.
  always_comb begin
    remain_s   = ACC_W'(N_COEF) - acc_cnt_r;
    take_cnt_s = {ACC_W{1'b0}};
    mask_s     = {LANES{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      if (lane_ok_s[i] && (take_cnt_s < remain_s)) begin
        mask_s[i]  = 1'b1;
        take_cnt_s = take_cnt_s + ACC_W'(1);
      end else begin
        mask_s[i]  = 1'b0;
      end
    end
    acc_next_s = acc_cnt_r + take_cnt_s;
  end

  // Control FSM with buffer, counters and the output beat register.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_r     <= ST_IDLE;
      buf_r       <= {BUF_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      acc_cnt_r   <= {ACC_W{1'b0}};
      out_coef_r  <= {EXT_W{1'b0}};
      out_mask_r  <= {LANES{1'b0}};
      out_valid_r <= 1'b0;
    end else if (start) begin
      state_r     <= ST_RUN;
      buf_r       <= {BUF_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      acc_cnt_r   <= {ACC_W{1'b0}};
      out_coef_r  <= {EXT_W{1'b0}};
      out_mask_r  <= {LANES{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (ext_s) begin
            acc_cnt_r <= acc_next_s;
            // An all-rejected beat is swallowed rather than presented downstream.
            if (mask_s != {LANES{1'b0}}) begin
              out_coef_r  <= buf_r[EXT_W-1:0];
              out_mask_r  <= mask_s;
              out_valid_r <= 1'b1;
            end else begin
              out_valid_r <= 1'b0;
            end
            if (acc_next_s == ACC_W'(N_COEF)) begin
              state_r <= ST_DONE;
              buf_r   <= {BUF_W{1'b0}};
              cnt_r   <= {CNT_W{1'b0}};
            end else begin
              buf_r   <= buf_next_s;
              cnt_r   <= cnt_next_s;
            end
          end else begin
            buf_r <= buf_next_s;
            cnt_r <= cnt_next_s;
            if (out_valid_r && out_ready) begin
              out_valid_r <= 1'b0;
            end else begin
              out_valid_r <= out_valid_r;
            end
          end
        end
        ST_IDLE, ST_DONE: begin
          if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
          end else begin
            out_valid_r <= out_valid_r;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef PARSE_STATS_EN
  localparam int unsigned LC_W = $clog2(LANES + 1);
  logic [LC_W-1:0] nrej_s;
  logic [16:0]     rej_sum_s;
  logic [15:0]     rej_cnt_r;

  // Lanes failing the modulus test; truncated-but-valid lanes are not rejections.
  always_comb begin
    nrej_s = {LC_W{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      if (!lane_ok_s[i]) begin
        nrej_s = nrej_s + LC_W'(1);
      end else begin
        nrej_s = nrej_s;
      end
    end
    rej_sum_s = {1'b0, rej_cnt_r} + 17'(nrej_s);
  end

  // Saturating rejection counter, cleared per polynomial.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rej_cnt_r <= 16'd0;
    end else if (start) begin
      rej_cnt_r <= 16'd0;
    end else if (ext_s) begin
      rej_cnt_r <= rej_sum_s[16] ? 16'hFFFF : rej_sum_s[15:0];
    end else begin
      rej_cnt_r <= rej_cnt_r;
    end
  end

  assign rej_cnt = rej_cnt_r;
`else
  assign rej_cnt = 16'd0;
`endif

  assign in_ready  = in_ready_s;
  assign out_coef  = out_coef_r;
  assign out_mask  = out_mask_r;
  assign out_valid = out_valid_r;
  assign busy      = (state_r == ST_RUN);
  assign done      = (state_r == ST_DONE);

endmodule
